// File: rtl/qubit_dispatcher.sv
// qubit_dispatcher: timed in-order issue stage. Buffers scheduled instruction
// words in a FIFO. The head word issues once the local timestamp reaches its
// start time and its target FPGAs are idle. Each issue keeps the FPGAs it
// used busy for OP_LATENCY cycles.
module qubit_dispatcher #(
    parameter int NUM_FPGA           = 64,
    parameter int NUM_QUBIT_PER_FPGA = 64,
    parameter int FIFO_DEPTH         = 8,
    parameter int OP_LATENCY         = 4,
    localparam int FW = $clog2(NUM_FPGA),
    localparam int QL = $clog2(NUM_QUBIT_PER_FPGA),
    localparam int Q  = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA),
    localparam int W  = 3 * Q + 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_instr,
    input  logic                time_en,
    output logic [15:0]         curr_time,
    output logic                issue_valid,
    output logic [FW-1:0]       issue_fpga,
    output logic [1:0]          issue_op,
    output logic [Q-1:0]        issue_op1,
    output logic [Q-1:0]        issue_op2,
    output logic [Q-1:0]        issue_dest,
    output logic [NUM_FPGA-1:0] fpga_busy,
    output logic                late_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OP_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t            state, state_nxt;
    logic [W-1:4]      mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [CW-1:0]     busy_cnt [NUM_FPGA];
    logic              head_late;

    logic              push, wr_en, pop;
    logic [W-1:4]      head;
    logic [1:0]        h_op;
    logic [Q-1:0]      h_op1, h_op2, h_dest;
    logic [15:0]       h_start, diff;
    logic [FW-1:0]     h_f1, h_f2, h_fd;
    logic              h_two, due, late, head_free;

    // Status bits [2:0] carry no meaning for dispatch.
    logic unused_status;
    assign unused_status = &{1'b0, in_instr[2:0]};

    assign push  = in_valid & in_ready;
    assign wr_en = push & in_instr[3];
    assign pop   = (state == S_ISSUE);

    assign head    = mem[rd_ptr];
    assign h_op    = head[W-1:W-2];
    assign h_op1   = head[W-3:2*Q+20];
    assign h_op2   = head[2*Q+19:Q+20];
    assign h_dest  = head[Q+19:20];
    assign h_start = head[19:4];
    assign h_f1    = h_op1[Q-1:QL];
    assign h_f2    = h_op2[Q-1:QL];
    assign h_fd    = h_dest[Q-1:QL];
    assign h_two   = h_op[1];

    assign diff      = h_start - curr_time;
    assign due       = (diff == 16'd0);
    assign late      = diff[15];
    assign head_free = !fpga_busy[h_fd] &&
                       (!h_two || (!fpga_busy[h_f1] && !fpga_busy[h_f2]));

    assign in_ready = (count < (AW+1)'(FIFO_DEPTH));

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_instr[W-1:4];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
        end
    end

    // Free-running timestamp, gated by time_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) curr_time <= '0;
        else if (time_en) curr_time <= curr_time + 16'd1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (count != '0) state_nxt = S_WAIT;
            S_WAIT:  if ((due || late) && head_free) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (count > (AW+1)'(1) || wr_en) ? S_WAIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lateness is judged when WAIT commits, since curr_time may advance
    // during the ISSUE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_late <= 1'b0;
            late_err  <= 1'b0;
        end else begin
            if (state == S_WAIT && state_nxt == S_ISSUE) head_late <= late;
            if (state == S_ISSUE && head_late) late_err <= 1'b1;
        end
    end

    // Per-FPGA busy counters: load on issue, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_FPGA; k++) busy_cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_FPGA; k++) begin
                if (pop && (FW'(k) == h_fd ||
                            (h_two && (FW'(k) == h_f1 || FW'(k) == h_f2))))
                    busy_cnt[k] <= CW'(OP_LATENCY);
                else if (busy_cnt[k] != '0)
                    busy_cnt[k] <= busy_cnt[k] - 1'b1;
            end
        end
    end

    // Busy flags derived from the counters.
    always_comb begin
        fpga_busy = '0;
        for (int unsigned k = 0; k < NUM_FPGA; k++)
            fpga_busy[k] = (busy_cnt[k] != '0);
    end

    // Issue port: head fields during ISSUE, zero otherwise.
    always_comb begin
        issue_valid = (state == S_ISSUE);
        issue_fpga  = '0;
        issue_op    = '0;
        issue_op1   = '0;
        issue_op2   = '0;
        issue_dest  = '0;
        if (issue_valid) begin
            issue_fpga = h_fd;
            issue_op   = h_op;
            issue_op1  = h_op1;
            issue_op2  = h_op2;
            issue_dest = h_dest;
        end
    end

endmodule
